fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Fetch stage directly downstream of the program counter.
- Takes each PC offered by the PC stage, issues a word read to instruction memory, and pairs each returned instruction with its PC.
- Buffers up to DEPTH fetches and presents them in order to decode over a valid/ready handshake.
- Decouples variable memory latency and decode stalls from the PC stage; flushes cleanly on branch redirect.

Parameters:
- DEPTH, 4, entry count of the fetch buffer. Power of two, minimum 2.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_valid  in  1  PC stage offers pc_in.
- pc_ready  out  1  fetch accepted this cycle; PC stage may advance.
- pc_in  in  XLEN  address to fetch.
- flush  in  1  branch redirect; discard all buffered and in-flight fetches.
- imem_req_valid  out  1  memory read request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned address, {pc_in[XLEN-1:2],2'b00}.
- imem_rsp_valid  in  1  read data returned; in order, at least 1 cycle after the accepted request.
- imem_rsp_data  in  XLEN  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode consumes it.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  XLEN  instruction word.
- if_misaligned  out  1  pc[1:0] was non-zero at issue.

Behaviour:
- Reset is asynchronous and active-low.
  - Clears all entry done bits, wr_ptr, rsp_ptr, rd_ptr, alloc_cnt and drop_cnt to 0.
  - Outputs during reset: imem_req_valid=0, pc_ready=0, if_valid=0, if_pc=0, if_instr=0, if_misaligned=0.
- Storage: DEPTH entries, each holding {pc, instr, misaligned, done}.
- Allocation:
  - alloc_cnt counts entries in use, whether issued-not-returned or returned-not-consumed.
  - alloc_cnt width is $clog2(DEPTH)+1.
- Issue:
  - imem_req_valid = pc_valid & !flush & (alloc_cnt < DEPTH).
  - pc_ready = imem_req_valid & imem_req_ready, combinational.
  - On pc_ready: entry[wr_ptr] gets pc=pc_in, misaligned=|pc_in[1:0], done=0; wr_ptr increments.
  - A misaligned PC still issues.
- Response, when imem_rsp_valid=1:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: entry[rsp_ptr].instr=imem_rsp_data, done=1; rsp_ptr increments.
  - A response with no outstanding request is a protocol violation; a simulation assertion fires.
- Output:
  - if_valid = (alloc_cnt != 0) & entry[rd_ptr].done.
  - if_pc, if_instr and if_misaligned come combinationally from entry[rd_ptr].
  - Pop on if_valid & if_ready: clear done and increment rd_ptr.
- Latency:
  - Minimum 2 cycles from PC acceptance to if_valid, with 1-cycle memory.
  - A response is visible to decode the cycle after it arrives; there is no same-cycle bypass.
- Throughput: one issue, one response and one pop may all occur in the same cycle.
  - alloc_cnt += issue − pop.
  - Full buffer with a same-cycle pop does not allow issue that cycle, because the credit check uses the registered alloc_cnt.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Flush has priority over every other event in that cycle:
  - No issue (pc_ready=0) and no pop committed.
  - All done bits cleared; alloc_cnt=0; all pointers reset to 0.
  - inflight = (wr_ptr − rsp_ptr mod DEPTH, or DEPTH when alloc_cnt==DEPTH with no entry done) + drop_cnt.
  - drop_cnt_next = inflight − (imem_rsp_valid ? 1 : 0). A response arriving in the flush cycle is itself discarded.
  - if_valid is forced to 0 in the flush cycle.
- Post-flush: new issues may start the next cycle; their responses are written only after drop_cnt reaches 0.
- Decode stall: with if_ready=0 the buffer fills to DEPTH, then pc_ready=0. Head outputs stay stable while if_valid=1 & if_ready=0.

Decomposition:
- Shared package fetch_pkg:
  - XLEN_DEFAULT and NOP_INSTR (32'h00000013).
  - typedef fetch_entry_t {pc, instr, misaligned, done}.
- One sub-module is natural: fetch_entry_ram, a DEPTH-entry register array with one allocate-write port, one response-write port, one combinational read port and a clear.
- Pointer, counter and drop logic stay in fetch_buffer.

Test Plan:
- Streaming, 1-cycle memory, if_ready=1, PCs 0x0, 0x4, 0x8 … → if_pc 0x0 valid at cycle 2, then one instruction per cycle, in order, paired with the matching PC.
- Decode stall: if_ready=0, pc_valid=1 → 4 issues, then pc_ready=0 with alloc_cnt=4. Raising if_ready → instructions from 0x0 onward; issue resumes one cycle after the first pop.
- Flush with 2 in-flight on 3-cycle memory → if_valid=0. The next 2 responses are dropped. Fetch of redirect PC 0x100 yields if_pc=0x100 with its own data, not the stale data.
- Flush coincident with imem_rsp_valid, 1 in flight plus the arriving one → drop_cnt=1; exactly one further response discarded.
- Reset asserted mid-stream with 3 entries full → all outputs 0 immediately (asynchronous). After release, fetch restarts cleanly from the offered PC.
- pc_in=0x6 → imem_req_addr=0x4, if_misaligned=1, if_pc=0x6.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
    logic                    misaligned;
    logic                    done;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_ram.sv
// DEPTH-entry fetch storage: allocate-write, response-write, one combinational
// read port (also the pop port) and a bulk clear of the done bits.
module fetch_entry_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            alloc_en,
  input  logic [PW-1:0]   alloc_idx,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            alloc_mis,
  input  logic            rsp_en,
  input  logic [PW-1:0]   rsp_idx,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            pop_en,
  input  logic [PW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_pc,
  output logic [XLEN-1:0] rd_instr,
  output logic            rd_mis,
  output logic            rd_done
);

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  pc_d    [DEPTH];
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [XLEN-1:0]  instr_d [DEPTH];
  logic [DEPTH-1:0] mis_q, mis_d;
  logic [DEPTH-1:0] done_q, done_d;

  // Clear only drops done bits; payload is stale but never presented as valid.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    done_d  = done_q;
    if (clear) begin
      done_d = '0;
    end else begin
      if (alloc_en) begin
        pc_d[alloc_idx]   = alloc_pc;
        mis_d[alloc_idx]  = alloc_mis;
        done_d[alloc_idx] = 1'b0;
      end
      if (rsp_en) begin
        instr_d[rsp_idx] = rsp_data;
        done_d[rsp_idx]  = 1'b1;
      end
      if (pop_en) begin
        done_d[rd_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      mis_q  <= '0;
      done_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
    end
  end

  assign rd_pc    = pc_q[rd_idx];
  assign rd_instr = instr_q[rd_idx];
  assign rd_mis   = mis_q[rd_idx];
  assign rd_done  = done_q[rd_idx];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues one imem read per accepted PC, pairs in-order responses
// with their PCs and hands them to decode; flush drops buffered and in-flight work.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Headroom for responses still owed from several back-to-back flushes.
  localparam int DW = PW + 3;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; pc_ready is that condition for the PC/imem-request pair.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rsp_ptr_q, rsp_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [DW-1:0] drop_cnt_q, drop_cnt_d;

  logic            head_done;
  logic [XLEN-1:0] head_pc, head_instr;
  logic            head_mis;
  logic            pop, rsp_wr, outstanding;
  logic [PW:0]     issued_out;
  logic [DW-1:0]   inflight;

  assign imem_req_valid = reset_n & pc_valid & ~flush & (alloc_cnt_q < CW'(DEPTH));
  assign pc_ready       = imem_req_valid & imem_req_ready;
  assign imem_req_addr  = {pc_in[XLEN-1:2], 2'b00};

  assign if_valid      = ~flush & (alloc_cnt_q != '0) & head_done;
  assign if_pc         = head_pc;
  assign if_instr      = head_instr;
  assign if_misaligned = head_mis;

  assign pop    = if_valid & if_ready;
  assign rsp_wr = imem_rsp_valid & ~flush & (drop_cnt_q == '0);

  // wr_ptr == rsp_ptr is ambiguous between none and DEPTH outstanding; a full
  // buffer whose head has not returned means every entry is still in flight.
  always_comb begin
    issued_out = {1'b0, wr_ptr_q - rsp_ptr_q};
    if (alloc_cnt_q == CW'(DEPTH) && !head_done) begin
      issued_out = CW'(DEPTH);
    end
    inflight    = DW'(issued_out) + drop_cnt_q;
    outstanding = (inflight != '0);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rsp_ptr_d   = rsp_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rsp_ptr_d   = '0;
      rd_ptr_d    = '0;
      alloc_cnt_d = '0;
      drop_cnt_d  = inflight - DW'(imem_rsp_valid);
    end else begin
      if (pc_ready) wr_ptr_d = wr_ptr_q + 1'b1;
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
        else                  rsp_ptr_d  = rsp_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      alloc_cnt_d = alloc_cnt_q + CW'(pc_ready) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rsp_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      alloc_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rsp_ptr_q   <= rsp_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fetch_entry_ram #(.DEPTH(DEPTH), .XLEN(XLEN)) u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .alloc_en  (pc_ready),
    .alloc_idx (wr_ptr_q),
    .alloc_pc  (pc_in),
    .alloc_mis (|pc_in[1:0]),
    .rsp_en    (rsp_wr),
    .rsp_idx   (rsp_ptr_q),
    .rsp_data  (imem_rsp_data),
    .pop_en    (pop),
    .rd_idx    (rd_ptr_q),
    .rd_pc     (head_pc),
    .rd_instr  (head_instr),
    .rd_mis    (head_mis),
    .rd_done   (head_done)
  );

  always @(posedge clk) begin
    if (reset_n && imem_rsp_valid) begin
      assert (outstanding) else $error("fetch_buffer: imem response with no outstanding request");
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with an in-order, fixed-latency imem model.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            pc_valid;
  logic            pc_ready;
  logic [XLEN-1:0] pc_in;
  logic            flush;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_misaligned;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  logic [XLEN-1:0] pend_addr_q[$];
  int              pend_due_q[$];
  logic [XLEN-1:0] next_pc;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .pc_in          (pc_in),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misaligned  (if_misaligned)
  );

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // ---------------- scoreboard check
  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock, with the imem model responding in order
  task automatic tick();
    logic            acc;
    logic [XLEN-1:0] a;
    #1;
    acc = pc_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (imem_rsp_valid && pend_addr_q.size() > 0) begin
      pend_addr_q.delete(0);
      pend_due_q.delete(0);
    end
    if (acc) begin
      pend_addr_q.push_back(a);
      pend_due_q.push_back(cyc + mem_lat - 1);
    end
    if (pend_addr_q.size() > 0 && pend_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr_q[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic clear_mem();
    pend_addr_q.delete();
    pend_due_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  // ---------------- directed sequence
  initial begin
    reset_n        = 1'b0;
    pc_valid       = 1'b1;
    pc_in          = 32'h10;
    flush          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_mis", if_misaligned, 0);
    reset_n  = 1'b1;
    pc_valid = 1'b0;
    #1;

    // Streaming, 1-cycle memory: first instruction at cycle 2, then one per cycle.
    mem_lat = 1;
    for (int i = 0; i < 8; i++) begin
      pc_valid = (i < 6);
      pc_in    = 32'(i * 4);
      #1;
      if (i < 6) chk("stream_pc_ready", pc_ready, 1);
      chk("stream_if_valid", if_valid, (i >= 2) ? 1 : 0);
      if (i >= 2) begin
        chk("stream_if_pc", if_pc, 32'((i - 2) * 4));
        chk("stream_if_instr", if_instr, mem_word(32'((i - 2) * 4)));
      end
      tick();
    end
    chk("stream_drained", dut.alloc_cnt_q, 0);

    // Decode stall: fills to DEPTH, then the PC stage is held off.
    if_ready = 1'b0;
    pc_valid = 1'b1;
    next_pc  = 32'h40;
    for (int j = 0; j < 6; j++) begin
      pc_in = next_pc;
      #1;
      chk("stall_pc_ready", pc_ready, (j < 4) ? 1 : 0);
      if (j < 4) next_pc = next_pc + 32'h4;
      tick();
    end
    chk("stall_alloc_full", dut.alloc_cnt_q, 4);
    chk("stall_if_valid", if_valid, 1);
    chk("stall_head_pc", if_pc, 32'h40);
    tick();
    chk("stall_head_stable", if_pc, 32'h40);
    chk("stall_instr_stable", if_instr, mem_word(32'h40));
    if_ready = 1'b1;
    pc_in    = next_pc;
    #1;
    chk("full_pop_no_issue", pc_ready, 0);
    chk("resume_pc0", if_pc, 32'h40);
    tick();
    chk("resume_issue", pc_ready, 1);
    chk("resume_pc1", if_pc, 32'h44);
    tick();
    pc_valid = 1'b0;
    #1;
    chk("resume_pc2", if_pc, 32'h48);
    tick();
    chk("resume_pc3", if_pc, 32'h4C);
    tick();
    chk("resume_late_valid", if_valid, 1);
    chk("resume_late_pc", if_pc, 32'h50);
    chk("resume_late_instr", if_instr, mem_word(32'h50));
    tick();
    chk("resume_drained", dut.alloc_cnt_q, 0);

    // Flush with two fetches in flight on 3-cycle memory.
    mem_lat  = 3;
    pc_valid = 1'b1;
    pc_in    = 32'h80;
    tick();
    pc_in = 32'h84;
    tick();
    flush = 1'b1;
    pc_in = 32'h100;
    #1;
    chk("flush_pc_ready", pc_ready, 0);
    chk("flush_req_valid", imem_req_valid, 0);
    chk("flush_if_valid", if_valid, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_drop2", dut.drop_cnt_q, 2);
    chk("post_flush_issue", pc_ready, 1);
    tick();
    pc_valid = 1'b0;
    #1;
    chk("flush_drop1", dut.drop_cnt_q, 1);
    chk("flush_stale0_hidden", if_valid, 0);
    tick();
    chk("flush_drop0", dut.drop_cnt_q, 0);
    chk("flush_stale1_hidden", if_valid, 0);
    tick();
    chk("redirect_no_bypass", if_valid, 0);
    tick();
    chk("redirect_valid", if_valid, 1);
    chk("redirect_pc", if_pc, 32'h100);
    chk("redirect_instr", if_instr, mem_word(32'h100));
    tick();
    chk("redirect_drained", dut.alloc_cnt_q, 0);

    // Flush coinciding with an arriving response: that one plus one more dropped.
    pc_valid = 1'b1;
    pc_in    = 32'hC0;
    tick();
    pc_in = 32'hC4;
    tick();
    pc_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("coinc_rsp_present", imem_rsp_valid, 1);
    chk("coinc_if_valid", if_valid, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("coinc_drop1", dut.drop_cnt_q, 1);
    tick();
    chk("coinc_drop0", dut.drop_cnt_q, 0);
    chk("coinc_alloc0", dut.alloc_cnt_q, 0);
    chk("coinc_if_valid_after", if_valid, 0);
    mem_lat  = 1;
    pc_valid = 1'b1;
    pc_in    = 32'hD0;
    tick();
    pc_valid = 1'b0;
    tick();
    chk("coinc_refetch_valid", if_valid, 1);
    chk("coinc_refetch_pc", if_pc, 32'hD0);
    chk("coinc_refetch_instr", if_instr, mem_word(32'hD0));
    tick();

    // Asynchronous reset with three entries occupied.
    if_ready = 1'b0;
    pc_valid = 1'b1;
    pc_in    = 32'h300;
    tick();
    pc_in = 32'h304;
    tick();
    pc_in = 32'h308;
    tick();
    chk("prerst_alloc", dut.alloc_cnt_q, 3);
    chk("prerst_if_pc", if_pc, 32'h300);
    pc_in = 32'h30C;
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_pc_ready", pc_ready, 0);
    chk("arst_if_valid", if_valid, 0);
    chk("arst_if_pc", if_pc, 0);
    chk("arst_if_instr", if_instr, 0);
    chk("arst_if_mis", if_misaligned, 0);
    clear_mem();
    repeat (2) @(posedge clk);
    #2;
    reset_n  = 1'b1;
    if_ready = 1'b1;
    pc_in    = 32'h400;
    #1;
    chk("restart_pc_ready", pc_ready, 1);
    tick();
    pc_valid = 1'b0;
    tick();
    chk("restart_valid", if_valid, 1);
    chk("restart_pc", if_pc, 32'h400);
    chk("restart_instr", if_instr, mem_word(32'h400));
    tick();
    chk("restart_drained", dut.alloc_cnt_q, 0);

    // Misaligned PC still issues, word-aligned, and is flagged.
    pc_valid = 1'b1;
    pc_in    = 32'h6;
    #1;
    chk("mis_req_valid", imem_req_valid, 1);
    chk("mis_req_addr", imem_req_addr, 32'h4);
    tick();
    pc_valid = 1'b0;
    tick();
    chk("mis_if_valid", if_valid, 1);
    chk("mis_if_pc", if_pc, 32'h6);
    chk("mis_flag", if_misaligned, 1);
    chk("mis_instr", if_instr, mem_word(32'h4));
    tick();
    chk("mis_drained", dut.alloc_cnt_q, 0);

    // ---------------- report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
